// File: rtl/cdc_isolate_pkg.sv
// Shared types for the CDC isolate/clear responder: FSM state encoding and a
// small helper used to size the shared down-counter.
package cdc_isolate_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN     = 3'd1,
    ISOLATED  = 3'd2,
    CLEARING  = 3'd3,
    CLEARED   = 3'd4
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cdc_isolate_responder_if.sv
// Local valid/ready stream seen by the responder: upstream side in, downstream
// side out toward the CDC half.
interface cdc_isolate_responder_if #(
  parameter type T = logic
);
  // A beat transfers on a cycle where valid & ready are both high; once valid
  // is raised it stays high with stable data until that cycle.
  logic up_valid;
  logic up_ready;
  T     up_data;
  logic dn_valid;
  logic dn_ready;
  T     dn_data;

  modport master (
    output up_valid, up_data, dn_ready,
    input  up_ready, dn_valid, dn_data
  );

  modport slave (
    input  up_valid, up_data, dn_ready,
    output up_ready, dn_valid, dn_data
  );
endinterface

// File: rtl/cdc_isolate_responder.sv
// Responder for the level-based isolate/clear handshake: drains an open beat
// before acknowledging isolation, and issues a fixed-length clear pulse.
module cdc_isolate_responder
  import cdc_isolate_pkg::*;
#(
  parameter type         T             = logic,
  parameter int unsigned DRAIN_TIMEOUT = 16,
  parameter int unsigned CLEAR_CYCLES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    isolate_req_i,
  output logic                    isolate_ack_o,
  input  logic                    clear_req_i,
  output logic                    clear_ack_o,
  output logic                    clear_o,
  output logic                    drain_timeout_o,
  output state_e                  dbg_state_o,
  cdc_isolate_responder_if.slave  s
);

  localparam int unsigned CNT_MAX = max_u(DRAIN_TIMEOUT, CLEAR_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'((DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

  if (CLEAR_CYCLES < 1) begin : g_bad_clear_cycles
    $error("CLEAR_CYCLES must be at least 1");
  end

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_drain_to;
  logic          w_to_set;
  logic          w_pass;
  T              w_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_drain_to <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_drain_to <= r_drain_to | w_to_set;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_set    = 1'b0;
    w_pass      = 1'b0;
    case (r_state)
      IDLE: begin
        w_pass = 1'b1;
        if (isolate_req_i) begin
          if (s.up_valid && !s.dn_ready) begin
            w_state_nxt = DRAIN;
            w_cnt_nxt   = DRAIN_LOAD;
          end else begin
            w_state_nxt = ISOLATED;
          end
        end
      end
      DRAIN: begin
        // The pass-through only carries the beat that was already open.
        w_pass = 1'b1;
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        if (!isolate_req_i) begin
          w_state_nxt = IDLE;
        end else if (!s.up_valid || s.dn_ready) begin
          w_state_nxt = ISOLATED;
        end else if (DRAIN_TIMEOUT != 0 && r_cnt == '0) begin
          w_state_nxt = ISOLATED;
          w_to_set    = 1'b1;
        end
      end
      ISOLATED: begin
        if (clear_req_i) begin
          w_state_nxt = CLEARING;
          w_cnt_nxt   = CLEAR_LOAD;
        end else if (!isolate_req_i) begin
          w_state_nxt = IDLE;
        end
      end
      CLEARING: begin
        // Pulse length is fixed once started; clear_req_i is not looked at.
        if (r_cnt == '0) w_state_nxt = CLEARED;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      CLEARED: begin
        if (!clear_req_i) w_state_nxt = ISOLATED;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_data          = s.up_data;
  assign s.dn_data       = w_data;
  assign s.dn_valid      = w_pass & s.up_valid;
  assign s.up_ready      = w_pass & s.dn_ready;
  assign isolate_ack_o   = (r_state == ISOLATED) || (r_state == CLEARING) || (r_state == CLEARED);
  assign clear_o         = (r_state == CLEARING);
  assign clear_ack_o     = (r_state == CLEARED);
  assign drain_timeout_o = r_drain_to;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_cdc_isolate_responder.sv
// Directed bench for cdc_isolate_responder (DRAIN_TIMEOUT=4, CLEAR_CYCLES=2):
// each step drives one cycle of inputs, queues the expected outputs, then checks.
module tb_cdc_isolate_responder;
  import cdc_isolate_pkg::*;

  typedef logic [7:0] data_t;
  localparam int W = 6 + 8;

  logic   clk = 1'b0;
  logic   rst;
  logic   isolate_req, isolate_ack, clear_req, clear_ack, clear_pulse, drain_to;
  state_e dbg_state;
  data_t  cur_data;

  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  cdc_isolate_responder_if #(.T(data_t)) bus ();

  cdc_isolate_responder #(
    .T             (data_t),
    .DRAIN_TIMEOUT (4),
    .CLEAR_CYCLES  (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .isolate_req_i   (isolate_req),
    .isolate_ack_o   (isolate_ack),
    .clear_req_i     (clear_req),
    .clear_ack_o     (clear_ack),
    .clear_o         (clear_pulse),
    .drain_timeout_o (drain_to),
    .dbg_state_o     (dbg_state),
    .s               (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic iso, input logic clr, input logic uv, input logic dr);
    isolate_req  = iso;
    clear_req    = clr;
    bus.up_valid = uv;
    bus.dn_ready = dr;
    cur_data     = data_t'($urandom_range(0, 255));
    bus.up_data  = cur_data;
  endtask

  // e = {isolate_ack, clear_ack, clear_o, up_ready, dn_valid, drain_timeout}
  task automatic push_exp(input logic [5:0] e);
    exp_q.push_back({e, cur_data});
  endtask

  task automatic check(input string tag);
    logic [W-1:0] exp_v, obs_v;
    exp_v = exp_q.pop_front();
    obs_v = {isolate_ack, clear_ack, clear_pulse, bus.up_ready, bus.dn_valid, drain_to, bus.dn_data};
    n_total++;
    assert (obs_v === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
  endtask

  task automatic step(input string tag, input logic iso, input logic clr,
                      input logic uv, input logic dr, input logic [5:0] e);
    @(posedge clk);
    #1;
    drive(iso, clr, uv, dr);
    push_exp(e);
    #1;
    check(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(6'b000010);
    #3;
    check("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Idle bus isolate: ack one cycle later, stream blocked while isolated
    step("t1_c0_req",     1, 0, 0, 0, 6'b000000);
    step("t1_c1_ack",     1, 0, 1, 1, 6'b100000);
    step("t1_c2_drop",    0, 0, 1, 1, 6'b100000);
    step("t1_c3_idle",    0, 0, 1, 1, 6'b000110);

    // Open beat drained by handshake at cycle 3
    step("t2_c0_open",    1, 0, 1, 0, 6'b000010);
    step("t2_c1_drain",   1, 0, 1, 0, 6'b000010);
    step("t2_c2_drain",   1, 0, 1, 0, 6'b000010);
    step("t2_c3_hs",      1, 0, 1, 1, 6'b000110);
    step("t2_c4_ack",     1, 0, 1, 1, 6'b100000);
    step("t2_c5_rel",     0, 0, 0, 0, 6'b100000);
    step("t2_c6_idle",    0, 0, 0, 0, 6'b000000);

    // Request dropped during drain: back to idle with no ack
    step("ab_c0_open",    1, 0, 1, 0, 6'b000010);
    step("ab_c1_abort",   0, 0, 1, 0, 6'b000010);
    step("ab_c2_idle",    0, 0, 1, 1, 6'b000110);

    // Upstream withdraws valid during drain
    step("wd_c0_open",    1, 0, 1, 0, 6'b000010);
    step("wd_c1_wdraw",   1, 0, 0, 0, 6'b000000);
    step("wd_c2_ack",     1, 0, 0, 0, 6'b100000);
    step("wd_c3_rel",     0, 0, 0, 0, 6'b100000);
    step("wd_c4_idle",    0, 0, 0, 0, 6'b000000);

    // Drain timeout: DRAIN for cycles 1-4, ack and sticky flag at cycle 5
    step("to_c0_open",    1, 0, 1, 0, 6'b000010);
    step("to_c1_drain",   1, 0, 1, 0, 6'b000010);
    step("to_c2_drain",   1, 0, 1, 0, 6'b000010);
    step("to_c3_drain",   1, 0, 1, 0, 6'b000010);
    step("to_c4_drain",   1, 0, 1, 0, 6'b000010);
    step("to_c5_ack",     1, 0, 1, 0, 6'b100001);
    step("to_c6_iso",     1, 0, 0, 0, 6'b100001);

    // Clear sequence: two-cycle pulse, ack, then release
    step("cl_req",        1, 1, 0, 0, 6'b100001);
    step("cl_pulse0",     1, 1, 0, 0, 6'b101001);
    step("cl_pulse1",     1, 1, 0, 0, 6'b101001);
    step("cl_ack",        1, 1, 0, 0, 6'b110001);
    step("cl_ack_hold",   1, 1, 0, 0, 6'b110001);
    step("cl_req_drop",   1, 0, 0, 0, 6'b110001);
    step("cl_ack_low",    1, 0, 0, 0, 6'b100001);
    step("cl_iso_drop",   0, 0, 0, 0, 6'b100001);
    step("cl_idle_pass",  0, 0, 1, 1, 6'b000111);

    // Early clear_req drop does not shorten the pulse
    step("ed_iso_req",    1, 0, 0, 0, 6'b000001);
    step("ed_clr_req",    1, 1, 0, 0, 6'b100001);
    step("ed_pulse0",     1, 0, 0, 0, 6'b101001);
    step("ed_pulse1",     1, 0, 0, 0, 6'b101001);
    step("ed_ack",        1, 0, 0, 0, 6'b110001);
    step("ed_ack_low",    1, 0, 0, 0, 6'b100001);
    step("ed_iso_drop",   0, 0, 0, 0, 6'b100001);
    step("ed_idle",       0, 0, 0, 0, 6'b000001);

    // clear_req in IDLE is ignored, then honoured once isolated
    step("ci_c0",         0, 1, 0, 0, 6'b000001);
    step("ci_c1",         0, 1, 0, 0, 6'b000001);
    step("ci_c2",         0, 1, 0, 0, 6'b000001);
    step("ci_iso_req",    1, 1, 0, 0, 6'b000001);
    step("ci_isolated",   1, 1, 0, 0, 6'b100001);
    step("ci_clearing",   1, 1, 0, 0, 6'b101001);

    // Reset mid-CLEARING: outputs drop without a clock edge
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    push_exp(6'b000110);
    #1;
    check("rst_async_drop");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    step("post_rst_pass", 0, 0, 1, 1, 6'b000110);
    step("post_rst_idle", 0, 0, 1, 0, 6'b000010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cdc_isolate_responder.md
Name: cdc_isolate_responder

Overview:
- Single-clock responder for the level-based isolate/clear request-acknowledge protocol issued by the CDC reset sequencer.
- Sits between a local valid/ready stream and a CDC half.
- On an isolate request it drains any open handshake (bounded by a timeout) before acknowledging, so valid is never withdrawn mid-beat.
- On a clear request it drives a local clear pulse of fixed length, then acknowledges.

Parameters:
- T, logic, payload type passed through on the stream.
- DRAIN_TIMEOUT, 16, max cycles spent waiting for an open handshake to complete; 0 = wait forever.
- CLEAR_CYCLES, 2, number of cycles clear_o is held high; must be >= 1, elaboration $error otherwise.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- isolate_req_i  in  1  level request to isolate the stream
- isolate_ack_o  out  1  level acknowledge of isolation
- clear_req_i  in  1  level request to clear local state (only while isolated)
- clear_ack_o  out  1  level acknowledge of completed clear
- clear_o  out  1  synchronous clear to local logic / CDC half
- up_valid_i  in  1  upstream valid
- up_ready_o  out  1  upstream ready
- up_data_i  in  T  upstream payload
- dn_valid_o  out  1  downstream valid
- dn_ready_i  in  1  downstream ready
- dn_data_o  out  T  downstream payload (combinational from up_data_i)
- drain_timeout_o  out  1  sticky flag: a drain ended by timeout

Behaviour:
- Reset (rst_i high, async): state IDLE, counter 0, drain_timeout_o 0. All outputs 0 except the combinational pass-through in IDLE.
- State is registered. All acks and clear_o decode from the state register only, so every ack rises exactly one cycle after the state transition is triggered.
- IDLE:
  - Pass-through: dn_valid_o=up_valid_i, up_ready_o=dn_ready_i.
  - On isolate_req_i, the next state depends on the same cycle's handshake:
    - up_valid_i & ~dn_ready_i -> DRAIN, counter loaded with DRAIN_TIMEOUT-1.
    - Otherwise, including a handshake firing that same cycle -> ISOLATED.
- DRAIN:
  - Pass-through stays active for the single open beat only.
  - Exit to ISOLATED on any of:
    - handshake (up_valid_i & dn_ready_i);
    - up_valid_i low (upstream withdrew);
    - counter==0 with DRAIN_TIMEOUT!=0, which also sets drain_timeout_o=1.
  - Counter decrements each cycle.
  - isolate_req_i dropping in DRAIN -> IDLE (abort, no ack issued).
- ISOLATED:
  - dn_valid_o=0, up_ready_o=0, isolate_ack_o=1.
  - clear_req_i -> CLEARING, counter loaded with CLEAR_CYCLES-1.
  - ~isolate_req_i & ~clear_req_i -> IDLE; isolate_ack_o falls the next cycle.
- CLEARING:
  - Stream blocked, isolate_ack_o=1, clear_o=1.
  - Counter decrements; at 0 -> CLEARED.
  - clear_req_i dropping early does not shorten the pulse.
- CLEARED:
  - Stream blocked, isolate_ack_o=1, clear_ack_o=1.
  - ~clear_req_i -> ISOLATED (clear_ack_o low the next cycle).
- clear_req_i outside ISOLATED/CLEARING/CLEARED is ignored. It is sampled again once ISOLATED is reached.
- Counter: one shared down-counter, width $clog2(max(DRAIN_TIMEOUT,CLEAR_CYCLES)+1). No wrap, because it is only decremented while non-zero.
- drain_timeout_o is cleared only by rst_i.
- Reset mid-operation, in any state, returns to IDLE immediately. Acks and clear_o drop asynchronously.

Decomposition:
- Package cdc_isolate_pkg holds the state enum (IDLE, DRAIN, ISOLATED, CLEARING, CLEARED, 3-bit encoding).
- No sub-module: a single FSM plus the shared counter, implemented inline.

Test Plan:
- Idle bus, isolate_req_i↑ at cycle 0 -> isolate_ack_o=1 at cycle 1; up_ready_o=dn_valid_o=0 from cycle 1.
- up_valid_i=1, dn_ready_i=0, isolate_req_i↑ at cycle 0, dn_ready_i↑ at cycle 3 -> dn_valid_o held 1 for cycles 0-3, handshake at 3, isolate_ack_o=1 at cycle 4, drain_timeout_o=0.
- DRAIN_TIMEOUT=4, dn_ready_i stuck 0, isolate_req_i↑ at cycle 0 -> DRAIN cycles 1-4, isolate_ack_o=1 at cycle 5, drain_timeout_o=1 and sticky until rst_i.
- Isolated, clear_req_i↑ at cycle 10, CLEAR_CYCLES=2 -> clear_o=1 at cycles 11-12, clear_ack_o=1 at 13. clear_req_i↓ at 15 -> clear_ack_o=0 at 16. isolate_req_i↓ at 17 -> isolate_ack_o=0 at 18 and pass-through restored.
- clear_req_i↑ while IDLE with isolate_req_i=0 -> clear_o stays 0 and clear_ack_o stays 0.
- rst_i pulsed during CLEARING -> clear_o and isolate_ack_o drop without waiting for a clock edge; after release, state is IDLE with pass-through active.
